dmem_bridge: RTL and testbench



---
 rtl/dmem_pkg.sv | 30 +++
 rtl/load_align.sv | 26 ++
 rtl/dmem_bridge.sv | 146 ++++++++++++++
 tb/tb_dmem_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path: funct3 width encodings and bridge FSM states.
// Also used by the memory-access stage so both sides agree on the width codes.
package dmem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusReq = 2'd1,
        StWaitR  = 2'd2,
        StDone   = 2'd3
    } bridge_state_e;

    // True when the width code is legal and the byte offset is naturally aligned for it.
    function automatic logic access_ok(input logic [2:0] width, input logic [1:0] offset);
        logic ok;
        case (width)
            MEM_B, MEM_BU: ok = 1'b1;
            MEM_H, MEM_HU: ok = ~offset[0];
            MEM_W:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Right-aligns the addressed lanes of a bus read word and sign- or zero-extends them.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  width_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (width_i)
            MEM_B:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  data_o = {24'h0, shifted[7:0]};
            MEM_H:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  data_o = {16'h0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the memory-access stage to a valid/ready data bus: one latched request at a time,
// byte strobes and lane replication for stores, aligned/extended load data, error and timeout.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_enable_i,
    input  logic [31:0] req_write_data_i,
    input  logic [2:0]  req_data_width_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    // Last counter value allowed before the wait is abandoned.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    bridge_state_e state_q;
    logic [31:0]   addr_q;
    logic [2:0]    width_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [7:0]    cnt_q;
    logic [31:0]   resp_data_q;
    logic          resp_err_q;

    logic [31:0]   load_data;
    logic [3:0]    strb;
    logic [31:0]   wdata_rep;

    load_align u_load_align (
        .rdata_i  (bus_rdata_i),
        .offset_i (addr_q[1:0]),
        .width_i  (width_q),
        .data_o   (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            width_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        width_q <= req_data_width_i;
                        we_q    <= req_write_enable_i;
                        wdata_q <= req_write_data_i;
                        if (access_ok(req_data_width_i, req_addr_i[1:0])) begin
                            state_q <= StBusReq;
                            cnt_q   <= '0;
                        end else begin
                            state_q     <= StDone;
                            resp_data_q <= '0;
                            resp_err_q  <= 1'b1;
                        end
                    end
                end
                StBusReq: begin
                    // A handshake in the final allowed cycle still wins over the timeout.
                    if (bus_ready_i) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (we_q) begin
                            state_q     <= StDone;
                            resp_data_q <= '0;
                            resp_err_q  <= 1'b0;
                        end else begin
                            state_q <= StWaitR;
                        end
                    end else if (cnt_q == TmoLast) begin
                        state_q     <= StDone;
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWaitR: begin
                    if (bus_rvalid_i) begin
                        state_q     <= StDone;
                        resp_data_q <= load_data;
                        resp_err_q  <= 1'b0;
                    end else if (cnt_q == TmoLast) begin
                        state_q     <= StDone;
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        strb      = 4'b0000;
        wdata_rep = wdata_q;
        case (width_q)
            MEM_B, MEM_BU: begin
                strb      = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            MEM_H, MEM_HU: begin
                strb      = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            MEM_W:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
    end

    assign bus_valid_o  = (state_q == StBusReq);
    assign bus_addr_o   = {addr_q[31:2], 2'b00};
    assign bus_we_o     = we_q;
    assign bus_wdata_o  = wdata_rep;
    assign bus_wstrb_o  = we_q ? strb : 4'b0000;
    assign stall_o      = ((state_q == StIdle) && req_valid_i) || (state_q == StBusReq) ||
                          (state_q == StWaitR);
    assign resp_valid_o = (state_q == StDone);
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scenario bench for dmem_bridge: expected responses are queued when a request is driven
// and compared against the responses collected from the DUT.
module tb_dmem_bridge;
    import dmem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_width;
    logic        stall, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    resp_t exp_q[$];
    resp_t act_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    // Observations from the most recent transaction
    int          r_stall, r_cyc;
    bit          r_done, r_seen, r_bv_done;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;
    logic        r_we;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_addr_i         (req_addr),
        .req_write_enable_i (req_we),
        .req_write_data_i   (req_wdata),
        .req_data_width_i   (req_width),
        .stall_o            (stall),
        .resp_valid_o       (resp_valid),
        .resp_data_o        (resp_data),
        .resp_err_o         (resp_err),
        .bus_valid_o        (bus_valid),
        .bus_ready_i        (bus_ready),
        .bus_addr_o         (bus_addr),
        .bus_we_o           (bus_we),
        .bus_wdata_o        (bus_wdata),
        .bus_wstrb_o        (bus_wstrb),
        .bus_rvalid_i       (bus_rvalid),
        .bus_rdata_i        (bus_rdata)
    );

    always @(negedge clk) begin
        if (reset && resp_valid) act_q.push_back({resp_data, resp_err});
    end

    task automatic sb_pop(output resp_t e, output resp_t a, output bit got);
        e = '0;
        a = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        got = (act_q.size() != 0);
        if (got) a = act_q.pop_front();
    endtask

    // Drives one request (called at posedge+1 with the DUT idle) and plays the bus side.
    // rdy_dly / rv_dly: wait cycles before bus_ready / bus_rvalid; -1 withholds them.
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [2:0] w, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rd, input bit keep);
        int bus_n, wait_n;
        bit in_wait, hs, bv;
        bus_n = 0; wait_n = 0; in_wait = 0;
        r_stall = 0; r_cyc = -1; r_done = 0; r_seen = 0; r_bv_done = 0;
        r_addr = '0; r_wdata = '0; r_strb = '0; r_we = 1'b0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_width = w;
        bus_rdata = rd;
        for (int c = 0; c < 64; c++) begin
            bus_ready  = bus_valid && (bus_n == rdy_dly);
            bus_rvalid = in_wait && (wait_n == rv_dly);
            @(negedge clk);
            if (stall) r_stall++;
            if (bus_valid && !r_seen) begin
                r_seen = 1; r_addr = bus_addr; r_wdata = bus_wdata;
                r_strb = bus_wstrb; r_we = bus_we;
            end
            if (resp_valid) begin
                r_done = 1; r_cyc = c; r_bv_done = bus_valid;
            end
            hs = bus_valid && bus_ready;
            bv = bus_valid;
            @(posedge clk); #1;
            bus_ready = 1'b0; bus_rvalid = 1'b0;
            if (r_done) break;
            if (in_wait) wait_n++;
            if (hs) begin
                if (!we) in_wait = 1;
            end else if (bv) begin
                bus_n++;
            end
        end
        if (!keep || !r_done) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_width = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({stall, resp_valid, resp_err, bus_valid, bus_we} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {stall, resp_valid, resp_err, bus_valid, bus_we});
        end else n_pass++;
        n_checks++;
        if ({resp_data, bus_addr, bus_wdata, bus_wstrb} !== 100'h0) begin
            $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
                     resp_data, bus_addr, bus_wdata, bus_wstrb);
        end else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        resp_t e, a;
        bit got;
        exp_q.push_back({32'h0, 1'b0});
        run_txn(32'h100, 1'b1, 32'hDEADBEEF, MEM_W, 2, -1, 32'h0, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e) $display("FAIL sw_resp: got %h expected %h", a, e);
        else n_pass++;
        n_checks++;
        if ({r_addr, r_strb, r_wdata, r_we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1})
            $display("FAIL sw_bus: got %h %b %h %b expected 00000100 1111 deadbeef 1",
                     r_addr, r_strb, r_wdata, r_we);
        else n_pass++;
        n_checks++;
        if (r_cyc !== 4 || r_stall !== 4)
            $display("FAIL sw_timing: got resp cycle %0d stall %0d expected 4 4", r_cyc, r_stall);
        else n_pass++;
    endtask

    task automatic test_store_narrow();
        resp_t e, a;
        bit got;
        exp_q.push_back({32'h0, 1'b0});
        run_txn(32'h203, 1'b1, 32'h000000A5, MEM_B, 0, -1, 32'h0, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e) $display("FAIL sb_resp: got %h expected %h", a, e);
        else n_pass++;
        n_checks++;
        if ({r_addr, r_strb, r_wdata} !== {32'h200, 4'b1000, 32'hA5A5A5A5})
            $display("FAIL sb_bus: got %h %b %h expected 00000200 1000 a5a5a5a5",
                     r_addr, r_strb, r_wdata);
        else n_pass++;
        n_checks++;
        if (r_cyc !== 2 || r_stall !== 2)
            $display("FAIL sb_timing: got resp cycle %0d stall %0d expected 2 2", r_cyc, r_stall);
        else n_pass++;
        exp_q.push_back({32'h0, 1'b0});
        run_txn(32'h202, 1'b1, 32'hBEEF1234, MEM_H, 1, -1, 32'h0, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e || {r_strb, r_wdata} !== {4'b1100, 32'h12341234})
            $display("FAIL sh_bus: got %b %h resp %h expected 1100 12341234 resp %h",
                     r_strb, r_wdata, a, e);
        else n_pass++;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [7] = '{32'h302, 32'h302, 32'h302, 32'h300, 32'h300, 32'h301, 32'h303};
        logic [2:0]  widths[7] = '{MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W, MEM_BU, MEM_B};
        logic [31:0] expd  [7] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F00,
                                   32'h80F17F00, 32'h0000007F, 32'hFFFFFF80};
        resp_t e, a;
        bit got;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({expd[i], 1'b0});
            run_txn(addrs[i], 1'b0, 32'hFFFFFFFF, widths[i], 0, 0, 32'h80F17F00, 1'b0);
            sb_pop(e, a, got);
            n_checks++;
            if (!got || a !== e) $display("FAIL load_%0d: got %h expected %h", i, a, e);
            else n_pass++;
            n_checks++;
            if (r_cyc !== 3 || r_stall !== 3 || r_strb !== 4'b0000 || r_we !== 1'b0 ||
                r_addr !== {addrs[i][31:2], 2'b00})
                $display("FAIL load_bus_%0d: got cyc %0d stall %0d strb %b we %b addr %h",
                         i, r_cyc, r_stall, r_strb, r_we, r_addr);
            else n_pass++;
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'hFFFFFF80)
            $display("FAIL load_hold: got valid %b data %h expected 0 ffffff80",
                     resp_valid, resp_data);
        else n_pass++;
        exp_q.push_back({32'h000080F1, 1'b0});
        run_txn(32'h302, 1'b0, 32'h0, MEM_HU, 1, 0, 32'h80F17F00, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e || r_cyc !== 4)
            $display("FAIL load_waitstate: got %h cyc %0d expected %h cyc 4", a, r_cyc, e);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [7] = '{32'h401, 32'h402, 32'h403, 32'h401, 32'h400, 32'h400, 32'h402};
        logic [2:0]  widths[7] = '{MEM_W, MEM_W, MEM_H, MEM_HU, 3'b011, 3'b110, MEM_W};
        logic        wes   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        resp_t e, a;
        bit got;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({32'h0, 1'b1});
            run_txn(addrs[i], wes[i], 32'h12345678, widths[i], 0, 0, 32'h80F17F00, 1'b0);
            sb_pop(e, a, got);
            n_checks++;
            if (!got || a !== e) $display("FAIL err_%0d: got %h expected %h", i, a, e);
            else n_pass++;
            n_checks++;
            if (r_cyc !== 1 || r_stall !== 1 || r_seen !== 1'b0)
                $display("FAIL err_timing_%0d: got cyc %0d stall %0d bus %b expected 1 1 0",
                         i, r_cyc, r_stall, r_seen);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        resp_t e, a;
        bit got;
        exp_q.push_back({32'h0, 1'b1});
        run_txn(32'h500, 1'b0, 32'h0, MEM_W, 0, -1, 32'hCAFEF00D, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e) $display("FAIL tmo_rd_resp: got %h expected %h", a, e);
        else n_pass++;
        n_checks++;
        if (r_cyc !== 5 || r_stall !== 5 || r_bv_done !== 1'b0)
            $display("FAIL tmo_rd_timing: got cyc %0d stall %0d bv %b expected 5 5 0",
                     r_cyc, r_stall, r_bv_done);
        else n_pass++;
        exp_q.push_back({32'h0, 1'b1});
        run_txn(32'h504, 1'b1, 32'h1, MEM_W, -1, -1, 32'h0, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e || r_cyc !== 5 || r_bv_done !== 1'b0)
            $display("FAIL tmo_req: got %h cyc %0d bv %b expected %h cyc 5 bv 0",
                     a, r_cyc, r_bv_done, e);
        else n_pass++;
        exp_q.push_back({32'hCAFEF00D, 1'b0});
        run_txn(32'h508, 1'b0, 32'h0, MEM_W, 0, 0, 32'hCAFEF00D, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e || r_cyc !== 3)
            $display("FAIL tmo_recover: got %h cyc %0d expected %h cyc 3", a, r_cyc, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        resp_t e, a;
        bit got;
        exp_q.push_back({32'h0, 1'b0});
        run_txn(32'h600, 1'b1, 32'h11223344, MEM_W, 0, -1, 32'h0, 1'b1);
        exp_q.push_back({32'h0000007F, 1'b0});
        run_txn(32'h601, 1'b0, 32'h0, MEM_BU, 0, 0, 32'h80F17F00, 1'b0);
        n_checks++;
        if (r_cyc !== 3 || r_stall !== 3 || r_addr !== 32'h600)
            $display("FAIL b2b_timing: got cyc %0d stall %0d addr %h expected 3 3 00000600",
                     r_cyc, r_stall, r_addr);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            sb_pop(e, a, got);
            n_checks++;
            if (!got || a !== e) $display("FAIL b2b_resp_%0d: got %h expected %h", i, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        resp_t e, a;
        bit got;
        req_valid = 1'b1; req_addr = 32'h700; req_we = 1'b0; req_width = MEM_W;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_valid !== 1'b1) $display("FAIL rst_mid_busreq: got %b expected 1", bus_valid);
        else n_pass++;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        n_checks++;
        if (bus_valid !== 1'b0 || stall !== 1'b1)
            $display("FAIL rst_mid_waitr: got bv %b stall %b expected 0 1", bus_valid, stall);
        else n_pass++;
        #2;
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus_valid, stall, resp_valid} !== 3'b000)
            $display("FAIL rst_mid_async: got %b expected 000", {bus_valid, stall, resp_valid});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({32'h12345678, 1'b0});
        run_txn(32'h704, 1'b0, 32'h0, MEM_W, 0, 0, 32'h12345678, 1'b0);
        sb_pop(e, a, got);
        n_checks++;
        if (!got || a !== e || r_cyc !== 3)
            $display("FAIL rst_mid_next: got %h cyc %0d expected %h cyc 3", a, r_cyc, e);
        else n_pass++;
        n_checks++;
        if (act_q.size() !== 0)
            $display("FAIL stray_resp: got %0d extra responses expected 0", act_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_narrow();
        test_loads();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
